operand_loader_8bit: RTL and testbench
======================================

// Module: operand_loader_8bit
//
// PURPOSE
//   Upstream stage of the 8-bit bitwise-operation datapath (AND/OR/XOR units).
//   Captures operand A, then operand B, from the board switches on successive
//   presses of a load button, and presents them to the operation stage with a
//   valid/ready handshake. Also synchronises and edge-detects the raw buttons.
//
// PARAMETERS
//   WIDTH        8   operand width in bits
//   SYNC_STAGES  2   flip-flops in each button synchroniser (>= 2)
//
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst_n      in   1      synchronous reset, active low
//   sw_data    in   WIDTH  switch value, sampled on a load event
//   btn_load   in   1      raw load button, active high, asynchronous
//   btn_clear  in   1      raw clear button, active high, asynchronous
//   op_ready   in   1      downstream stage accepts the operand pair
//   op_a       out  WIDTH  operand A to operation stage
//   op_b       out  WIDTH  operand B to operation stage
//   op_valid   out  1      op_a/op_b complete and stable
//   state      out  2      FSM state for LEDs: 00 LOAD_A, 01 LOAD_B, 10 VALID
//
// BEHAVIOUR
//   - Reset (rst_n low at a clk edge): op_a=0, op_b=0, op_valid=0,
//     state=LOAD_A, all synchroniser and edge-detect flops = 0.
//   - Each button: SYNC_STAGES-deep synchroniser, then rising-edge detect
//     (last stage & ~its registered copy) -> one-cycle pulse per press,
//     regardless of press length. Button held across reset release yields
//     exactly one pulse.
//   - Latency: btn_load high before edge n -> register update at edge
//     n+SYNC_STAGES (edge n+2 with default).
//   - FSM, evaluated each edge, clear_pulse has top priority:
//     clear_pulse (any state): op_a=0, op_b=0, op_valid=0 -> LOAD_A.
//     LOAD_A: load_pulse -> op_a<=sw_data, -> LOAD_B.
//     LOAD_B: load_pulse -> op_b<=sw_data, op_valid<=1, -> VALID.
//     VALID:  load_pulse ignored; op_a/op_b held; op_ready=1 at edge ->
//             op_valid<=0, -> LOAD_A (op_a/op_b keep values until reloaded).
//   - op_valid is registered and asserted at the same edge op_b is written.
//     A handshake completes on any edge where op_valid & op_ready.
//   - op_ready is ignored outside VALID.
//   - Same-cycle load and clear pulses: clear wins, sw_data not captured.
//   - Unused state code 11: next edge -> LOAD_A with clear semantics.
//   - No arithmetic; sw_data copied bit-exact, WIDTH bits, no extension.
//
// TESTING
//   1 Reset: hold rst_n=0 2 cycles -> op_a=00, op_b=00, op_valid=0, state=00.
//   2 sw=0xF0, press load; sw=0x3C, press load -> op_a=F0, op_b=3C,
//     op_valid=1 at edge n+2 after 2nd press, state=10.
//   3 In VALID, op_ready=0 for 5 cycles, sw=0xFF + load press -> op_a/op_b
//     unchanged, op_valid stays 1; then op_ready=1 one cycle -> op_valid=0,
//     state=00.
//   4 Hold btn_load high 20 cycles in LOAD_A -> exactly one capture, state=01
//     (not 10).
//   5 In LOAD_B with op_a=0xAA, press clear -> op_a=00, op_b=00, state=00;
//     load and clear pulses in same cycle -> clear result, no capture.
//   6 Button glitch changing between edges / held through rst_n release ->
//     at most one pulse; after release, no capture until next press.

Source files
------------

// File: rtl/operand_loader_8bit_if.sv
// Operand loader bus: switch/button inputs and the operand-pair handshake to the operation stage.
// The slave modport is the loader's view of the bus; the master modport is the board/downstream side.
interface operand_loader_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_data;
    logic             btn_load;
    logic             btn_clear;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic [1:0]       state;

    modport master (
        output sw_data, btn_load, btn_clear, op_ready,
        input  op_a, op_b, op_valid, state
    );

    modport slave (
        input  sw_data, btn_load, btn_clear, op_ready,
        output op_a, op_b, op_valid, state
    );
endinterface

// File: rtl/operand_loader_8bit.sv
// Captures operand A then B from the switches on successive load presses and offers the pair
// downstream with valid/ready; raw buttons are synchronised and turned into one-cycle pulses.
module operand_loader_8bit #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    operand_loader_8bit_if.slave bus
);
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        VALID   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] clear_sync;
    logic                   load_last;
    logic                   clear_last;
    logic                   load_pulse;
    logic                   clear_pulse;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;

    // Clearing the edge-detect copy in reset makes a button held through reset count as one press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_sync  <= '0;
            clear_sync <= '0;
            load_last  <= 1'b0;
            clear_last <= 1'b0;
        end else begin
            load_sync  <= {load_sync[SYNC_STAGES-2:0], bus.btn_load};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], bus.btn_clear};
            load_last  <= load_sync[SYNC_STAGES-1];
            clear_last <= clear_sync[SYNC_STAGES-1];
        end
    end

    assign load_pulse  = load_sync[SYNC_STAGES-1] & ~load_last;
    assign clear_pulse = clear_sync[SYNC_STAGES-1] & ~clear_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        // Clear outranks everything, including a load pulse in the same cycle.
        if (clear_pulse || state_q == ILLEGAL) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: if (load_pulse) begin
                    a_d     = bus.sw_data;
                    state_d = LOAD_B;
                end
                LOAD_B: if (load_pulse) begin
                    b_d     = bus.sw_data;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
                VALID: if (bus.op_ready) begin
                    // Operands stay on the bus after the handshake until overwritten.
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign bus.op_a     = a_q;
    assign bus.op_b     = b_q;
    assign bus.op_valid = valid_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_operand_loader_8bit.sv
// Bench for operand_loader_8bit: directed scenarios plus randomized traffic against a
// press-history / phase reference model.
module tb_operand_loader_8bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    operand_loader_8bit_if #(.WIDTH(8)) bus ();

    operand_loader_8bit #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: a press acts at edge E when the button was sampled high at E-2 and low at E-3.
    bit         lh[$];
    bit         ch[$];
    logic [7:0] ma, mb;
    bit         mv;
    logic [1:0] ms;

    task automatic tick();
        bit lp, cp;
        @(posedge clk);
        if (!rst_n) begin
            lh = '{0, 0, 0, 0};
            ch = '{0, 0, 0, 0};
            ma = 8'h00; mb = 8'h00; mv = 1'b0; ms = 2'd0;
        end else begin
            lp = lh[$-1] && !lh[$-2];
            cp = ch[$-1] && !ch[$-2];
            lh.push_back(bus.btn_load);  void'(lh.pop_front());
            ch.push_back(bus.btn_clear); void'(ch.pop_front());
            if (cp) begin
                ma = 8'h00; mb = 8'h00; mv = 1'b0; ms = 2'd0;
            end else if (ms == 2'd0 && lp) begin
                ma = bus.sw_data; ms = 2'd1;
            end else if (ms == 2'd1 && lp) begin
                mb = bus.sw_data; mv = 1'b1; ms = 2'd2;
            end else if (ms == 2'd2 && bus.op_ready) begin
                mv = 1'b0; ms = 2'd0;
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(2);
        vectors++;
        if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {8'h00, 8'h00, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset: got a=%h b=%h v=%b st=%b, want 00 00 0 00",
                     bus.op_a, bus.op_b, bus.op_valid, bus.state);
        end
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic test_load_pair();
        bus.sw_data = 8'hF0; bus.btn_load = 1'b1; ticks(3);
        bus.btn_load = 1'b0; ticks(2);
        vectors++;
        if ({bus.op_a, bus.state} !== {8'hF0, 2'b01}) begin
            miscompares++;
            $display("FAIL load_a: got a=%h st=%b, want F0 01", bus.op_a, bus.state);
        end
        bus.sw_data = 8'h3C; bus.btn_load = 1'b1;
        tick();  // edge n
        tick();  // edge n+1
        vectors++;
        if (bus.op_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got v=%b at n+1, want 0", bus.op_valid);
        end
        tick();  // edge n+2
        vectors++;
        if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {8'hF0, 8'h3C, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL load_pair: got a=%h b=%h v=%b st=%b, want F0 3C 1 10",
                     bus.op_a, bus.op_b, bus.op_valid, bus.state);
        end
        bus.btn_load = 1'b0; ticks(2);
    endtask

    task automatic test_valid_hold();
        bus.op_ready = 1'b0; bus.sw_data = 8'hFF;
        bus.btn_load = 1'b1; ticks(3);
        bus.btn_load = 1'b0; ticks(3);
        vectors++;
        if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {8'hF0, 8'h3C, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL valid_hold: got a=%h b=%h v=%b st=%b, want F0 3C 1 10",
                     bus.op_a, bus.op_b, bus.op_valid, bus.state);
        end
        bus.op_ready = 1'b1; tick();
        bus.op_ready = 1'b0;
        vectors++;
        if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {8'hF0, 8'h3C, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL handshake: got a=%h b=%h v=%b st=%b, want F0 3C 0 00",
                     bus.op_a, bus.op_b, bus.op_valid, bus.state);
        end
        bus.op_ready = 1'b1; ticks(2);  // ready outside VALID must be ignored
        bus.op_ready = 1'b0;
        vectors++;
        if (bus.state !== 2'b00) begin
            miscompares++;
            $display("FAIL ready_ignored: got st=%b, want 00", bus.state);
        end
    endtask

    task automatic test_long_press();
        bus.sw_data = 8'h5A; bus.btn_load = 1'b1; ticks(5);
        bus.sw_data = 8'h11; ticks(15);
        bus.btn_load = 1'b0; ticks(3);
        vectors++;
        if ({bus.op_a, bus.op_valid, bus.state} !== {8'h5A, 1'b0, 2'b01}) begin
            miscompares++;
            $display("FAIL long_press: got a=%h v=%b st=%b, want 5A 0 01",
                     bus.op_a, bus.op_valid, bus.state);
        end
    endtask

    task automatic test_clear();
        bus.btn_clear = 1'b1; ticks(2); bus.btn_clear = 1'b0; ticks(2);
        bus.sw_data = 8'hAA; bus.btn_load = 1'b1; ticks(2); bus.btn_load = 1'b0; ticks(3);
        vectors++;
        if ({bus.op_a, bus.state} !== {8'hAA, 2'b01}) begin
            miscompares++;
            $display("FAIL clear_setup: got a=%h st=%b, want AA 01", bus.op_a, bus.state);
        end
        bus.btn_clear = 1'b1; ticks(3); bus.btn_clear = 1'b0; ticks(2);
        vectors++;
        if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {8'h00, 8'h00, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL clear: got a=%h b=%h v=%b st=%b, want 00 00 0 00",
                     bus.op_a, bus.op_b, bus.op_valid, bus.state);
        end
        bus.sw_data = 8'h99; bus.btn_load = 1'b1; bus.btn_clear = 1'b1; ticks(3);
        bus.btn_load = 1'b0; bus.btn_clear = 1'b0; ticks(3);
        vectors++;
        if ({bus.op_a, bus.state} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL load_clear_same: got a=%h st=%b, want 00 00", bus.op_a, bus.state);
        end
    endtask

    task automatic test_glitch_reset();
        bus.sw_data = 8'h42; bus.btn_load = 1'b1;
        rst_n = 1'b0; ticks(3);
        rst_n = 1'b1; ticks(6);
        vectors++;
        if ({bus.op_a, bus.state} !== {8'h42, 2'b01}) begin
            miscompares++;
            $display("FAIL held_reset: got a=%h st=%b, want 42 01", bus.op_a, bus.state);
        end
        bus.btn_load = 1'b0; ticks(3);
        for (int i = 0; i < 4; i++) begin
            #1 bus.btn_load = 1'b1;
            #2 bus.btn_load = 1'b0;
            tick();
        end
        ticks(2);
        vectors++;
        if ({bus.op_b, bus.state} !== {8'h00, 2'b01}) begin
            miscompares++;
            $display("FAIL glitch_between_edges: got b=%h st=%b, want 00 01", bus.op_b, bus.state);
        end
        bus.sw_data = 8'hC3;
        #7 bus.btn_load = 1'b1;  // straddles exactly one edge
        @(posedge clk); #2 bus.btn_load = 1'b0;
        ticks(4);
        vectors++;
        if ({bus.op_b, bus.op_valid, bus.state} !== {8'hC3, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL glitch_one_edge: got b=%h v=%b st=%b, want C3 1 10",
                     bus.op_b, bus.op_valid, bus.state);
        end
        // the bare posedge above bypassed the model; resync model with a reset
        rst_n = 1'b0; ticks(2); rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.sw_data = 8'($urandom);
            if ($urandom_range(3) == 0) bus.btn_load = ~bus.btn_load;
            bus.btn_clear = ($urandom_range(15) == 0);
            bus.op_ready = ($urandom_range(2) == 0);
            tick();
            vectors++;
            if ({bus.op_a, bus.op_b, bus.op_valid, bus.state} !== {ma, mb, mv, ms}) begin
                miscompares++;
                $display("FAIL random[%0d]: got a=%h b=%h v=%b st=%b, want %h %h %b %b",
                         i, bus.op_a, bus.op_b, bus.op_valid, bus.state, ma, mb, mv, ms);
            end
        end
    endtask

    initial begin
        bus.sw_data = 8'h00; bus.btn_load = 1'b0; bus.btn_clear = 1'b0; bus.op_ready = 1'b0;
        lh = '{0, 0, 0, 0};
        ch = '{0, 0, 0, 0};
        #1;
        test_reset();
        test_load_pair();
        test_valid_hold();
        test_long_press();
        test_clear();
        test_glitch_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
